// File: rtl/riscv_cfg_pkg.sv
// Shared definitions for the RISC-V instruction-config packet path.
// The transmit-side loader and the leaf-side decoder both use this package.
package riscv_cfg_pkg;

    localparam int PACKET_BITS   = 49;
    localparam int PAYLOAD_BITS  = 32;
    localparam int NUM_LEAF_BITS = 5;
    localparam int NUM_PORT_BITS = 4;
    localparam int NUM_ADDR_BITS = 7;
    localparam int ADDR_BITS     = 24;

    // Packet valid flag position (the MSB of the packet).
    localparam int VALID_POS = PACKET_BITS - 1;

    // Leaf port that decodes a packet as an instruction-memory byte write.
    localparam logic [NUM_PORT_BITS-1:0] CONFIG_PORT = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        FIN   = 2'd3
    } ld_state_t;

    // Build a valid config packet:
    // {valid, leaf, port, bram_addr=0, payload={addr, data_byte}}.
    function automatic logic [PACKET_BITS-1:0] pack_cfg(
        input logic [NUM_LEAF_BITS-1:0] leaf,
        input logic [NUM_PORT_BITS-1:0] port,
        input logic [ADDR_BITS-1:0]     addr,
        input logic [7:0]               data_byte
    );
        logic [PAYLOAD_BITS-1:0] payload;
        payload  = {addr, data_byte};
        pack_cfg = {1'b1, leaf, port, {NUM_ADDR_BITS{1'b0}}, payload};
    endfunction

endpackage

// File: rtl/riscv_cfg_pkt_reg.sv
// Outgoing packet register.
// While a valid packet is being refused (resend=1), the packet is frozen so that
// the same packet is presented again on the next cycle.
module riscv_cfg_pkt_reg
    import riscv_cfg_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   clear,
    input  logic                   resend,
    input  logic [PACKET_BITS-1:0] pkt_in,
    output logic [PACKET_BITS-1:0] pkt_out
);

    logic hold;

    // A refused valid packet must not change, whatever the controller asks for.
    assign hold = pkt_out[VALID_POS] & resend;

    // Packet register: hold on refusal, otherwise clear or load on request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pkt_out <= '0;
        else if (!hold) begin
            if (clear)
                pkt_out <= '0;
            else if (load)
                pkt_out <= pkt_in;
        end
    end

endmodule

// File: rtl/riscv_instr_loader_tx.sv
// Instruction loader, transmit side.
// Takes 32-bit words from the host stream and sends each word as four
// little-endian byte writes, each carried in a BFT packet to the config port
// of the chosen leaf.
module riscv_instr_loader_tx
    import riscv_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [23:0] base_addr,
    input  logic [15:0] num_words,
    input  logic [4:0]  dst_leaf,
    input  logic [31:0] din,
    input  logic        val_in,
    output logic        ready_upward,
    output logic [48:0] dout_leaf_interface2bft,
    input  logic        resend,
    output logic        busy,
    output logic        done
);

    ld_state_t   state;
    logic [23:0] addr_q;
    logic [15:0] num_words_q;
    logic [15:0] word_cnt;
    logic [1:0]  byte_idx;
    logic [4:0]  leaf_q;
    logic [31:0] word_q;

    logic        accept;
    logic        last_byte;
    logic [7:0]  nxt_byte;
    logic        pkt_load;
    logic        pkt_clear;
    logic [48:0] pkt_next;

    assign ready_upward = (state == FETCH);
    assign accept       = (state == SEND) & ~resend;
    assign last_byte    = (byte_idx == 2'd3);

    // Pick the byte that follows the one currently on the bus.
    always_comb begin
        nxt_byte = word_q[15:8];
        case (byte_idx)
            2'd0:    nxt_byte = word_q[15:8];
            2'd1:    nxt_byte = word_q[23:16];
            default: nxt_byte = word_q[31:24];
        endcase
    end

    // Packet register control: load byte0 on fetch, load the next byte on an
    // accept inside a word, and drop valid after the last byte of a word.
    always_comb begin
        pkt_load  = 1'b0;
        pkt_clear = 1'b0;
        pkt_next  = '0;
        if (state == FETCH && val_in) begin
            pkt_load = 1'b1;
            pkt_next = pack_cfg(leaf_q, CONFIG_PORT, addr_q, din[7:0]);
        end else if (accept && !last_byte) begin
            pkt_load = 1'b1;
            pkt_next = pack_cfg(leaf_q, CONFIG_PORT, addr_q + 24'd1, nxt_byte);
        end else if (accept && last_byte) begin
            pkt_clear = 1'b1;
        end
    end

    riscv_cfg_pkt_reg u_pkt_reg (
        .clk     (clk),
        .rst_n   (resetn),
        .load    (pkt_load),
        .clear   (pkt_clear),
        .resend  (resend),
        .pkt_in  (pkt_next),
        .pkt_out (dout_leaf_interface2bft)
    );

    // Load FSM with its counters; busy and done are registered here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            addr_q      <= '0;
            num_words_q <= '0;
            word_cnt    <= '0;
            byte_idx    <= '0;
            leaf_q      <= '0;
            word_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q      <= base_addr;
                        num_words_q <= num_words;
                        leaf_q      <= dst_leaf;
                        word_cnt    <= '0;
                        byte_idx    <= '0;
                        busy        <= 1'b1;
                        if (num_words == 16'd0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (val_in) begin
                        word_q   <= din;
                        byte_idx <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (!resend) begin
                        addr_q <= addr_q + 24'd1;
                        if (!last_byte) begin
                            byte_idx <= byte_idx + 2'd1;
                        end else begin
                            byte_idx <= '0;
                            word_cnt <= word_cnt + 16'd1;
                            if (word_cnt + 16'd1 == num_words_q) begin
                                state <= FIN;
                                done  <= 1'b1;
                            end else begin
                                state <= FETCH;
                            end
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_instr_loader_tx.sv
// Directed, table-driven bench for riscv_instr_loader_tx.
// Each vector is one clock cycle: the inputs driven in that cycle and the
// outputs expected while they are applied (before the next rising edge).
module tb_riscv_instr_loader_tx;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [23:0] base_addr = '0;
    logic [15:0] num_words = '0;
    logic [4:0]  dst_leaf = '0;
    logic [31:0] din = '0;
    logic        val_in = 1'b0;
    logic        ready_upward;
    logic [48:0] pkt;
    logic        resend = 1'b0;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_instr_loader_tx dut (
        .clk                     (clk),
        .resetn                  (resetn),
        .start                   (start),
        .base_addr               (base_addr),
        .num_words               (num_words),
        .dst_leaf                (dst_leaf),
        .din                     (din),
        .val_in                  (val_in),
        .ready_upward            (ready_upward),
        .dout_leaf_interface2bft (pkt),
        .resend                  (resend),
        .busy                    (busy),
        .done                    (done)
    );

    typedef struct {
        logic        st;
        logic [23:0] base;
        logic [15:0] nw;
        logic [4:0]  leaf;
        logic [31:0] din;
        logic        val;
        logic        rs;
        logic        e_rdy;
        logic        e_busy;
        logic        e_done;
        logic [48:0] e_pkt;
    } vec_t;

    vec_t vq[$];
    int   t1_len;

    // Expected packet: valid, leaf, port 0, bram addr 0, payload.
    function automatic logic [48:0] mkp(input logic [4:0] leaf, input logic [31:0] payload);
        return {1'b1, leaf, 4'd0, 7'd0, payload};
    endfunction

    task automatic add(input logic st, input logic [23:0] base, input logic [15:0] nw,
                       input logic [4:0] leaf, input logic [31:0] d, input logic val,
                       input logic rs, input logic e_rdy, input logic e_busy,
                       input logic e_done, input logic [48:0] e_pkt);
        vec_t v;
        v.st = st; v.base = base; v.nw = nw; v.leaf = leaf; v.din = d; v.val = val;
        v.rs = rs; v.e_rdy = e_rdy; v.e_busy = e_busy; v.e_done = e_done; v.e_pkt = e_pkt;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic r, input logic b, input logic d,
                       input logic [48:0] p);
        n_vec++;
        if (ready_upward !== r || busy !== b || done !== d || pkt !== p) begin
            n_err++;
            $display("FAIL %s: got rdy=%b busy=%b done=%b pkt=%h, want rdy=%b busy=%b done=%b pkt=%h",
                     nm, ready_upward, busy, done, pkt, r, b, d, p);
        end
    endtask

    task automatic apply(input int idx);
        @(negedge clk);
        start = vq[idx].st; base_addr = vq[idx].base; num_words = vq[idx].nw;
        dst_leaf = vq[idx].leaf; din = vq[idx].din; val_in = vq[idx].val;
        resend = vq[idx].rs;
        #1;
        chk($sformatf("vec%0d", idx), vq[idx].e_rdy, vq[idx].e_busy, vq[idx].e_done, vq[idx].e_pkt);
    endtask

    initial begin
        // Test 1: one word, leaf 3, base 0x100.
        add(1, 24'h000100, 16'd1, 5'd3, 32'h0, 0, 0, 0, 0, 0, '0);
        add(0, 24'h0, 16'd0, 5'd0, 32'hDEADBEEF, 1, 0, 1, 1, 0, '0);
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 0, mkp(5'd3, 32'h000100EF));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 0, mkp(5'd3, 32'h000101BE));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 0, mkp(5'd3, 32'h000102AD));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 0, mkp(5'd3, 32'h000103DE));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 1, '0);
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 0, 0, '0);
        t1_len = vq.size();
        // Test 2: resend held three cycles on byte 2.
        add(1, 24'h000200, 16'd1, 5'd7, 32'h0, 0, 0, 0, 0, 0, '0);
        add(0, 24'h0, 16'd0, 5'd0, 32'h11223344, 1, 0, 1, 1, 0, '0);
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 0, mkp(5'd7, 32'h00020044));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 0, mkp(5'd7, 32'h00020133));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 1, 0, 1, 0, mkp(5'd7, 32'h00020222));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 1, 0, 1, 0, mkp(5'd7, 32'h00020222));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 1, 0, 1, 0, mkp(5'd7, 32'h00020222));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 0, mkp(5'd7, 32'h00020222));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 0, mkp(5'd7, 32'h00020311));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 1, '0);
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 0, 0, '0);
        // Test 3: two words across the 24-bit address wrap; val_in during SEND
        // is not consumed; one idle FETCH cycle between words.
        add(1, 24'hFFFFFE, 16'd2, 5'd1, 32'h0, 0, 0, 0, 0, 0, '0);
        add(0, 24'h0, 16'd0, 5'd0, 32'hA3A2A1A0, 1, 0, 1, 1, 0, '0);
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 0, mkp(5'd1, 32'hFFFFFEA0));
        add(0, 24'h0, 16'd0, 5'd0, 32'hCAFEF00D, 1, 0, 0, 1, 0, mkp(5'd1, 32'hFFFFFFA1));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 0, mkp(5'd1, 32'h000000A2));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 0, mkp(5'd1, 32'h000001A3));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 1, 1, 0, '0);
        add(0, 24'h0, 16'd0, 5'd0, 32'hB3B2B1B0, 1, 0, 1, 1, 0, '0);
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 0, mkp(5'd1, 32'h000002B0));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 0, mkp(5'd1, 32'h000003B1));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 0, mkp(5'd1, 32'h000004B2));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 0, mkp(5'd1, 32'h000005B3));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 1, '0);
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 0, 0, '0);
        // Test 4: zero words -> done next cycle, no packet, no ready.
        add(1, 24'h000400, 16'd0, 5'd4, 32'h0, 0, 0, 0, 0, 0, '0);
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 1, '0);
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 0, 0, '0);
        // Test 5: start pulses mid-load with another base/leaf are ignored.
        add(1, 24'h000300, 16'd1, 5'd2, 32'h0, 0, 0, 0, 0, 0, '0);
        add(1, 24'h000999, 16'd3, 5'd9, 32'h55667788, 1, 0, 1, 1, 0, '0);
        add(1, 24'h000999, 16'd3, 5'd9, 32'h0, 0, 0, 0, 1, 0, mkp(5'd2, 32'h00030088));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 0, mkp(5'd2, 32'h00030177));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 0, mkp(5'd2, 32'h00030266));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 0, mkp(5'd2, 32'h00030355));
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 1, 1, '0);
        add(0, 24'h0, 16'd0, 5'd0, 32'h0, 0, 0, 0, 0, 0, '0);

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("reset", 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < vq.size(); i++) apply(i);

        // Test 6: reset asserted while byte 1 is on the bus.
        for (int i = 0; i < 4; i++) apply(i);
        resetn = 1'b0;
        #1;
        chk("async_reset", 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        start = 1'b0; val_in = 1'b0; resend = 1'b0; din = '0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("post_reset_idle", 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        chk("no_stale_done", 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < t1_len; i++) apply(i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
